led_pwm_array: RTL

Multi-channel LED driver that generalises the board's single breathing-LED fader. Each of NCH outputs independently runs off, on, blink or breathe at a per-channel brightness, using first-order sigma-delta PWM. All channels share one prescaler and one phase counter so blinking and breathing stay in lockstep, with a sync input to realign them. Sits at the top level next to the status logic that drives the front-panel LEDs.

---
 rtl/led_pwm_array.sv | 118 +++++++++++
 1 files changed

// File: rtl/led_pwm_array.sv
// Multi-channel LED driver: off/on/blink/breathe per channel with
// first-order sigma-delta PWM, all channels sharing one phase counter.
module led_pwm_array #(
  parameter int NCH           = 4,
  parameter int PWMBITS       = 5,
  parameter int PRESCALE_BITS = 22
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [2*NCH-1:0]           mode,
  input  logic [NCH*(PWMBITS+1)-1:0] level,
  input  logic                       sync,
  output logic [NCH-1:0]             led,
  output logic                       tick
);

  localparam int LW = PWMBITS + 1;
  localparam int PW = 2 * LW - 1;
  localparam logic [LW-1:0] FULL = LW'(1 << PWMBITS);

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_ON      = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_BREATHE = 2'b11;

  logic [PRESCALE_BITS-1:0] presc;
  logic [LW-1:0]            phase;
  logic                     wrap;
  logic                     dir;
  logic [PWMBITS-1:0]       ramp;

  logic [2*NCH-1:0] mode_r;
  logic [LW-1:0]    level_r  [NCH];
  logic [LW-1:0]    lvl_sat  [NCH];
  logic [LW-1:0]    duty     [NCH];
  logic [LW-1:0]    duty_nx  [NCH];
  logic [LW-1:0]    acc      [NCH];
  logic [LW-1:0]    sum      [NCH];
  logic [LW-1:0]    brth     [NCH];

  assign wrap = &presc;
  assign dir  = phase[PWMBITS];
  assign ramp = dir ? phase[PWMBITS-1:0]
                    : ~phase[PWMBITS-1:0];

  // sync restarts the shared timebase and swallows a pending tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      phase <= '0;
      tick  <= 1'b0;
    end else if (sync) begin
      presc <= '0;
      phase <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      tick  <= wrap;
      if (wrap) begin
        phase <= phase + 1'b1;
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      lvl_sat[ch] = '0;
      brth[ch]    = '0;
      duty_nx[ch] = '0;
      sum[ch]     = '0;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      lvl_sat[ch] = (level[LW*ch +: LW] > FULL) ? FULL
                                                 : level[LW*ch +: LW];
      brth[ch] = LW'(({{LW{1'b0}}, ramp}
                    * {{PWMBITS{1'b0}}, level_r[ch]})
                    >> PWMBITS);
      unique case (mode_r[2*ch +: 2])
        M_OFF:     duty_nx[ch] = '0;
        M_ON:      duty_nx[ch] = level_r[ch];
        M_BLINK:   duty_nx[ch] = dir ? '0 : level_r[ch];
        M_BREATHE: duty_nx[ch] = brth[ch];
      endcase
      sum[ch] = {1'b0, acc[ch][PWMBITS-1:0]} + duty[ch];
    end
  end

  // acc is never cleared by mode/level/sync so transitions stay smooth
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_r <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        level_r[ch] <= '0;
        duty[ch]    <= '0;
        acc[ch]     <= '0;
      end
    end else begin
      mode_r <= mode;
      for (int ch = 0; ch < NCH; ch++) begin
        level_r[ch] <= lvl_sat[ch];
        duty[ch]    <= duty_nx[ch];
        acc[ch]     <= sum[ch];
      end
    end
  end

  // the acc MSB is the registered carry of the last step
  always_comb begin
    led = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      led[ch] = acc[ch][PWMBITS];
    end
  end

  logic unused_pw;
  assign unused_pw = ^{PW{1'b0}};

endmodule
